// File: rtl/sobel_pkg.sv
// Shared types and defaults for the pixel memory arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   ADDR_W_DEF   : default pixel memory address width
//   DATA_W_DEF   : default pixel data width
package sobel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (read/write) arbiter in front of a single pixel memory with a
// fixed read latency. One access is in flight at a time; an access takes
// LATENCY+3 cycles from request sample to the return to IDLE.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests. Without it, a read always wins a tie.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rd_req, rd_addr             read request (held until rd_grant)
//   rd_grant, rd_valid, rd_data read grant pulse, data-valid pulse, data
//   wr_req, wr_addr, wr_data    write request (held until wr_grant)
//   wr_grant, wr_done           write grant pulse, completion pulse
//   mem_en, mem_we              memory strobe and direction
//   mem_addr, mem_wdata         memory address and write data (latched)
//   mem_rdata                   memory read data, LATENCY cycles after mem_en
//   busy                        high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | sample requests, latch winner/address/data
// ISSUE | one-cycle memory strobe, grant pulse, load latency counter
// WAIT  | count down LATENCY cycles; read data captured on the last one
// DONE  | one-cycle rd_valid / wr_done pulse, back to IDLE
module mem_arbiter
   import sobel_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LATENCY = 2            // legal range 1..4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_grant,
   output logic              wr_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [2:0] LAT_LOAD = 3'(LATENCY);

   arb_state_t        state_q;
   logic [2:0]        cnt_q;
   logic              win_wr_q;
   logic              rd_grant_q, wr_grant_q, rd_valid_q, wr_done_q;
   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, rd_data_q;
   logic              pick_wr_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic              last_wr_q;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      pick_wr_d = wr_req;
      if (rd_req && wr_req) pick_wr_d = !last_wr_q;
   end
`else
   always_comb begin
      pick_wr_d = wr_req && !rd_req;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         win_wr_q    <= 1'b0;
         rd_grant_q  <= 1'b0;
         wr_grant_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         wr_done_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_data_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_wr_q   <= 1'b1;
`endif
      end else begin
         // Pulses and the memory strobe default low every cycle.
         rd_grant_q <= 1'b0;
         wr_grant_q <= 1'b0;
         rd_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd_req || wr_req) begin
                  win_wr_q   <= pick_wr_d;
                  mem_addr_q <= pick_wr_d ? wr_addr : rd_addr;
                  if (pick_wr_d) mem_wdata_q <= wr_data;
                  mem_en_q   <= 1'b1;
                  mem_we_q   <= pick_wr_d;
                  rd_grant_q <= !pick_wr_d;
                  wr_grant_q <= pick_wr_d;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q     <= LAT_LOAD;
`ifdef ARB_ROUND_ROBIN_EN
               last_wr_q <= win_wr_q;
`endif
               state_q   <= WAIT;
            end
            WAIT: begin
               // Terminal count at 1: this is the last WAIT cycle, and the
               // cycle in which mem_rdata is valid for the issued read.
               if (cnt_q == 3'd1) begin
                  cnt_q      <= 3'd0;
                  if (!win_wr_q) rd_data_q <= mem_rdata;
                  rd_valid_q <= !win_wr_q;
                  wr_done_q  <= win_wr_q;
                  state_q    <= DONE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rd_grant  = rd_grant_q;
   assign wr_grant  = wr_grant_q;
   assign rd_valid  = rd_valid_q;
   assign wr_done   = wr_done_q;
   assign rd_data   = rd_data_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req, wr_req;
   logic [15:0] rd_addr, wr_addr;
   logic [7:0]  wr_data, mem_rdata;
   logic        rd_grant, rd_valid, wr_grant, wr_done;
   logic        mem_en, mem_we, busy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, rd_data;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(8), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_grant(wr_grant), .wr_done(wr_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   typedef struct {
      logic        rst;
      logic        rd_req;
      logic [15:0] rd_addr;
      logic        wr_req;
      logic [15:0] wr_addr;
      logic [7:0]  wr_data;
      logic [7:0]  mem_rdata;
      logic [38:0] exp;
   } vec_t;

   // {rd_grant, wr_grant, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, wr_done, busy}
   function automatic logic [38:0] pk(logic rg, logic wg, logic en, logic we,
                                      logic [15:0] a, logic [7:0] wd, logic rv,
                                      logic [7:0] rdat, logic wdn, logic bsy);
      return {rg, wg, en, we, a, wd, rv, rdat, wdn, bsy};
   endfunction

   function automatic logic [38:0] outs();
      return {rd_grant, wr_grant, mem_en, mem_we, mem_addr, mem_wdata,
              rd_valid, rd_data, wr_done, busy};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic rq, input logic [15:0] ra,
                        input logic wq, input logic [15:0] wa, input logic [7:0] wd,
                        input logic [7:0] md);
      rst = r; rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa;
      wr_data = wd; mem_rdata = md;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 8'h0);
      step();
      rst = 1'b0;
   endtask

   vec_t vecs[12];

   initial begin
      // Read at cycle 0 then a write at cycle 6 (LATENCY=2).
      vecs[0]  = '{0, 1, 16'h0010, 0, 16'h0000, 8'h00, 8'h00, pk(0,0,0,0,16'h0000,8'h00,0,8'h00,0,0)};
      vecs[1]  = '{0, 1, 16'h0010, 0, 16'h0000, 8'h00, 8'h00, pk(1,0,1,0,16'h0010,8'h00,0,8'h00,0,1)};
      vecs[2]  = '{0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, pk(0,0,0,0,16'h0010,8'h00,0,8'h00,0,1)};
      vecs[3]  = '{0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'hA5, pk(0,0,0,0,16'h0010,8'h00,0,8'h00,0,1)};
      vecs[4]  = '{0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, pk(0,0,0,0,16'h0010,8'h00,1,8'hA5,0,1)};
      vecs[5]  = '{0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, pk(0,0,0,0,16'h0010,8'h00,0,8'hA5,0,0)};
      vecs[6]  = '{0, 0, 16'h0000, 1, 16'h0020, 8'h3C, 8'h00, pk(0,0,0,0,16'h0010,8'h00,0,8'hA5,0,0)};
      vecs[7]  = '{0, 0, 16'h0000, 1, 16'h0020, 8'h3C, 8'h00, pk(0,1,1,1,16'h0020,8'h3C,0,8'hA5,0,1)};
      vecs[8]  = '{0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, pk(0,0,0,0,16'h0020,8'h3C,0,8'hA5,0,1)};
      vecs[9]  = '{0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h5A, pk(0,0,0,0,16'h0020,8'h3C,0,8'hA5,0,1)};
      vecs[10] = '{0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, pk(0,0,0,0,16'h0020,8'h3C,0,8'hA5,1,1)};
      vecs[11] = '{0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00, pk(0,0,0,0,16'h0020,8'h3C,0,8'hA5,0,0)};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].rst, vecs[i].rd_req, vecs[i].rd_addr, vecs[i].wr_req,
               vecs[i].wr_addr, vecs[i].wr_data, vecs[i].mem_rdata);
         @(negedge clk);
         chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
         step();
      end

      // Reset in the middle of a read: abort, no valid, rd_data cleared.
      for (int c = 0; c < 7; c++) begin
         drive(c == 2, c < 2, 16'h0044, 1'b0, 16'h0, 8'h0, (c == 3) ? 8'h77 : 8'h00);
         @(negedge clk);
         if (c == 3) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rd_data", 64'(rd_data), 64'h00);
            chk("rst_mem_addr", 64'(mem_addr), 64'h0000);
         end
         if (c >= 3) chk($sformatf("rst_no_valid_c%0d", c), 64'(rd_valid), 64'd0);
         step();
      end

      // Write raised during a read waits for the read to finish.
      for (int c = 0; c < 11; c++) begin
         logic [3:0] e;
         drive(1'b0, c < 2, 16'h0050, (c >= 2) && (c <= 6), 16'h0030, 8'h99,
               (c == 3) ? 8'h5C : 8'h00);
         @(negedge clk);
         e = (c == 1) ? 4'b1000 : (c == 4) ? 4'b0010 : (c == 6) ? 4'b0100 :
             (c == 9) ? 4'b0001 : 4'b0000;
         chk($sformatf("rdwr_pulses_c%0d", c), 64'({rd_grant, wr_grant, rd_valid, wr_done}), 64'(e));
         if (c == 4) chk("rdwr_rd_data", 64'(rd_data), 64'h5C);
         if (c == 6) chk("rdwr_wr_issue", 64'({mem_en, mem_we, mem_addr, mem_wdata}),
                         64'({1'b1, 1'b1, 16'h0030, 8'h99}));
         step();
      end

      // Both requests held continuously from cycle 0.
      do_reset();
      for (int c = 0; c < 18; c++) begin
         logic [1:0] e;
         drive(1'b0, 1'b1, 16'h0060, 1'b1, 16'h0070, 8'h11, 8'h00);
         @(negedge clk);
         e = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
         if (c == 1 || c == 11) e = 2'b10;
         if (c == 6 || c == 16) e = 2'b01;
`else
         if (c == 1 || c == 6 || c == 11 || c == 16) e = 2'b10;
`endif
         chk($sformatf("tie_c%0d", c), 64'({rd_grant, wr_grant}), 64'(e));
         step();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
